div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 14 +
 rtl/div_passo.sv | 20 ++
 rtl/div_seq.sv | 118 +++++++++++
 tb/tb_div_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int N_DEF = 8;

  // Wide enough for any practical N; div_seq slices it to its own width.
  localparam logic [63:0] QUOC_DIV0 = '1;

  typedef enum logic {
    OCIOSO = 1'b0,
    CALC   = 1'b1
  } estado_t;

endpackage

// File: rtl/div_passo.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_passo #(
  parameter int N = 8
) (
  input  logic [N:0]   rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? (shifted[N:0] - {1'b0, divisor}) : shifted[N:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: one restoring step per clock, N steps per operation.
module div_seq
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic         ocupado,
  output logic [N-1:0] quoc,
  output logic [N:0]   rest,
  output logic         fim_div
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quoc_q, quoc_d;
  logic [N:0]    rest_q, rest_d;
  logic          ocupado_q, ocupado_d;
  logic          fim_q, fim_d;

  logic [N:0]    rem_new;
  logic          q_bit;

  div_passo #(.N(N)) u_passo (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[N-1]),
    .divisor (dsr_q),
    .rem_out (rem_new),
    .q_bit   (q_bit)
  );

  // The dividend register doubles as the quotient accumulator: each step
  // consumes its MSB and shifts the new quotient bit in at the LSB.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quoc_d    = quoc_q;
    rest_d    = rest_q;
    ocupado_d = ocupado_q;
    fim_d     = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          if (divisor != '0) begin
            dvd_d     = dividendo;
            dsr_d     = divisor;
            rem_d     = '0;
            cnt_d     = '0;
            estado_d  = CALC;
            ocupado_d = 1'b1;
          end else begin
            quoc_d = QUOC_DIV0[N-1:0];
            rest_d = {1'b0, dividendo};
            fim_d  = 1'b1;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[N-2:0], q_bit};
        rem_d = rem_new;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          quoc_d    = {dvd_q[N-2:0], q_bit};
          rest_d    = rem_new;
          fim_d     = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses <= so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quoc_q    <= '0;
      rest_q    <= '0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quoc_q    <= quoc_d;
      rest_q    <= rest_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign ocupado = ocupado_q;
  assign quoc    = quoc_q;
  assign rest    = rest_q;
  assign fim_div = fim_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes a/b, a%b and the expected completion cycle.
module tb_div_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic         ocupado;
  logic [N-1:0] quoc;
  logic [N:0]   rest;
  logic         fim_div;

  div_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .ocupado   (ocupado),
    .quoc      (quoc),
    .rest      (rest),
    .fim_div   (fim_div)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [N:0]   r;
    int           at;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] last_q = '0;
  logic [N:0]   last_r = '0;
  int           busy_lo = 0;
  int           busy_hi = 0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: ocupado window, completion results and latency, hold between completions.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ocupado", 64'(ocupado), 64'((cyc >= busy_lo) && (cyc < busy_hi)));
      if (fim_div) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fim: fim_div=1 required 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quoc", 64'(quoc), 64'(e.q));
          check("rest", 64'(rest), 64'(e.r));
          check("latency", 64'(cyc), 64'(e.at));
          last_q = e.q;
          last_r = e.r;
        end
      end else begin
        check("hold_quoc", 64'(quoc), 64'(last_q));
        check("hold_rest", 64'(rest), 64'(last_r));
      end
    end
  end

  // Issues one operation; returns at the edge after which the next may be driven back-to-back.
  task automatic op(input int a, input int b, input bit hold);
    int   k;
    exp_t x;
    @(negedge clk);
    inicio    = 1'b1;
    dividendo = N'(a);
    divisor   = N'(b);
    @(posedge clk);
    #1;
    k = cyc;
    if (b != 0) begin
      x.q = N'(a / b);
      x.r = (N + 1)'(a % b);
      x.at = k + N;
      busy_lo = k;
      busy_hi = k + N;
    end else begin
      x.q = {N{1'b1}};
      x.r = (N + 1)'(a);
      x.at = k;
    end
    sb.push_back(x);
    if (hold) begin
      dividendo = N'(9);
      divisor   = N'(2);
      repeat (N) @(posedge clk);
      #1;
      inicio = 1'b0;
    end else begin
      inicio = 1'b0;
      if (b != 0) repeat (N) @(posedge clk);
    end
  endtask

  initial begin
    int a, b, k;
    rst = 1'b1;
    inicio = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ocupado", 64'(ocupado), 64'(0));
    check("rst_fim", 64'(fim_div), 64'(0));
    check("rst_quoc", 64'(quoc), 64'(0));
    check("rst_rest", 64'(rest), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    op(100, 7, 1'b0);
    repeat (3) @(posedge clk);
    op(255, 1, 1'b0);
    op(5, 9, 1'b0);
    repeat (2) @(posedge clk);
    op(37, 0, 1'b0);
    repeat (2) @(posedge clk);
    op(200, 3, 1'b1);
    op(0, 13, 1'b0);
    repeat (2) @(posedge clk);

    // Abort 100/7 with a reset on the fourth edge after acceptance.
    @(negedge clk);
    inicio = 1'b1;
    dividendo = N'(100);
    divisor = N'(7);
    @(posedge clk);
    #1;
    k = cyc;
    busy_lo = k;
    busy_hi = k + N;
    inicio = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_lo = 0;
    busy_hi = 0;
    last_q = '0;
    last_r = '0;
    op(50, 5, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = ($urandom % 20 == 0) ? 0 : int'($urandom_range(0, 255));
      b = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, 255));
      op(a, b, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending required 0", sb.size());
    end
    repeat (N + 4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
